// File: rtl/hack_alu_seq.sv
// hack_alu_seq: multi-cycle sequencer for one Hack CPU instruction at a time.
// The ALU is external: this block drives its operands and control bits during EXEC
// and captures the result and flags on the EXEC clock edge.
//
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   instr, instr_valid,
//   instr_ready               instruction handshake (accepted only in IDLE)
//   alu_x, alu_y,
//   zx, nx, zy, ny, f, no     ALU drive (all zero outside EXEC)
//   alu_out, zr, ng           ALU return
//   mem_addr, mem_wdata,
//   mem_rdata, mem_req,
//   mem_we, mem_ack           data memory port (read in FETCHM, write in WRITEM)
//   pc, a_reg, d_reg, done    architectural state, one-cycle retire pulse
//
// Build option: define HACK_ALU_SEQ_MEM_WAIT_EN to make FETCHM and WRITEM wait for
// mem_ack. Without it each memory state lasts one cycle, mem_ack is ignored and
// mem_rdata must be valid in the same cycle as mem_req.
module hack_alu_seq (
   input  logic        clock,
   input  logic        reset_n,
   // instruction handshake
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   // ALU drive
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic        zx,
   output logic        nx,
   output logic        zy,
   output logic        ny,
   output logic        f,
   output logic        no,
   // ALU return
   input  logic [15:0] alu_out,
   input  logic        zr,
   input  logic        ng,
   // memory
   output logic [14:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ack,
   // status
   output logic [14:0] pc,
   output logic [15:0] a_reg,
   output logic [15:0] d_reg,
   output logic        done
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetchm = 3'd1,
      StExec   = 3'd2,
      StWritem = 3'd3,
      StRetire = 3'd4
   } state_e;

   state_e      state_q, state_d;

   logic [15:0] ir;
   logic [15:0] m;
   logic [15:0] a_old;
   logic [15:0] res_q;
   logic        zr_q;
   logic        ng_q;
   logic        mem_go;
   logic        jump;

`ifdef HACK_ALU_SEQ_MEM_WAIT_EN
   assign mem_go = mem_ack;
`else
   // Memory states always complete in one cycle; the ack input is deliberately unused.
   logic unused_mem_ack;
   assign unused_mem_ack = mem_ack;
   assign mem_go         = 1'b1;
`endif

   // Jump condition from the flags captured at the end of EXEC.
   assign jump = (ir[2] & ng_q) | (ir[1] & zr_q) | (ir[0] & ~zr_q & ~ng_q);

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; decode uses instr directly in IDLE since ir loads on that edge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (instr_valid) begin
               if (!instr[15])     state_d = StRetire;
               else if (instr[12]) state_d = StFetchm;
               else                state_d = StExec;
            end
         end
         StFetchm: if (mem_go) state_d = StExec;
         StExec:   state_d = ir[3] ? StWritem : StRetire;
         StWritem: if (mem_go) state_d = StRetire;
         StRetire: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      instr_ready = 1'b0;
      alu_x       = 16'h0000;
      alu_y       = 16'h0000;
      {zx, nx, zy, ny, f, no} = 6'b000000;
      mem_addr    = 15'h0000;
      mem_wdata   = 16'h0000;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      done        = 1'b0;
      unique case (state_q)
         // Gated by reset_n so ready reads 0 while reset is held.
         StIdle: instr_ready = reset_n;
         StFetchm: begin
            mem_req  = 1'b1;
            mem_addr = a_reg[14:0];
         end
         StExec: begin
            {zx, nx, zy, ny, f, no} = ir[11:6];
            alu_x = d_reg;
            alu_y = ir[12] ? m : a_reg;
         end
         StWritem: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = a_old[14:0];
            mem_wdata = res_q;
         end
         StRetire: done = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc    <= 15'h0000;
         a_reg <= 16'h0000;
         d_reg <= 16'h0000;
         ir    <= 16'h0000;
         m     <= 16'h0000;
         a_old <= 16'h0000;
         res_q <= 16'h0000;
         zr_q  <= 1'b0;
         ng_q  <= 1'b0;
      end else begin
         if (state_q == StIdle && instr_valid) begin
            ir <= instr;
         end
         if (state_q == StFetchm && mem_go) begin
            m <= mem_rdata;
         end
         // a_old holds the A value seen by this instruction: M address and jump target.
         if (state_d == StExec && state_q != StExec) begin
            a_old <= a_reg;
         end
         if (state_q == StExec) begin
            res_q <= alu_out;
            zr_q  <= zr;
            ng_q  <= ng;
            if (ir[5]) a_reg <= alu_out;
            if (ir[4]) d_reg <= alu_out;
         end
         if (state_q == StRetire) begin
            if (!ir[15]) begin
               a_reg <= ir;
               pc    <= pc + 15'd1;
            end else begin
               pc <= jump ? a_old[14:0] : pc + 15'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hack_alu_seq.sv
// tb_hack_alu_seq: directed-vector bench for hack_alu_seq with a behavioural Hack ALU
// and a simple memory responder (ack after ack_delay request cycles).
module tb_hack_alu_seq;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] alu_x, alu_y, alu_out;
   logic        zx, nx, zy, ny, f, no, zr, ng;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [14:0] pc;
   logic [15:0] a_reg, d_reg;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   hack_alu_seq dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_x       (alu_x),
      .alu_y       (alu_y),
      .zx          (zx),
      .nx          (nx),
      .zy          (zy),
      .ny          (ny),
      .f           (f),
      .no          (no),
      .alu_out     (alu_out),
      .zr          (zr),
      .ng          (ng),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_ack     (mem_ack),
      .pc          (pc),
      .a_reg       (a_reg),
      .d_reg       (d_reg),
      .done        (done)
   );

   always #5 clock = ~clock;

   // Behavioural Hack ALU
   logic [15:0] mx, my, mr;
   always_comb begin
      mx = alu_x;
      my = alu_y;
      if (zx) mx = 16'h0000;
      if (nx) mx = ~mx;
      if (zy) my = 16'h0000;
      if (ny) my = ~my;
      mr = f ? (mx + my) : (mx & my);
      if (no) mr = ~mr;
   end
   assign alu_out = mr;
   assign zr      = (mr == 16'h0000);
   assign ng      = mr[15];

   // Memory responder: ack after ack_delay cycles of request; read data valid only with ack.
   int          ack_delay = 0;
   int          req_cnt = 0;
   int          wr_count = 0;
   logic [15:0] rd_val = 16'h0000;
   assign mem_ack   = mem_req && (req_cnt == ack_delay);
   assign mem_rdata = mem_ack ? rd_val : 16'hDEAD;

   always @(posedge clock) begin
      req_cnt <= mem_req ? req_cnt + 1 : 0;
      if (mem_req && mem_we) wr_count <= wr_count + 1;
   end

   // Observations collected while an instruction runs
   logic [5:0]  seen_ctrl;
   logic [15:0] seen_y;
   int          we_cycles;
   logic [14:0] we_addr;
   logic [15:0] we_data;
   int          rd_cycles;
   logic [14:0] rd_addr;
   logic        rd_addr_moved;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one instruction from a negedge in IDLE; returns latency counting the accept
   // cycle, or 0 on timeout. Returns at the negedge after done, with the DUT back in IDLE.
   task automatic run_instr(input logic [15:0] i, output int lat);
      seen_ctrl = 6'b0; seen_y = 16'h0; we_cycles = 0; we_addr = 15'h0; we_data = 16'h0;
      rd_cycles = 0; rd_addr = 15'h0; rd_addr_moved = 1'b0;
      instr = i;
      instr_valid = 1'b1;
      @(posedge clock);
      #1 instr_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clock);
         if ({zx, nx, zy, ny, f, no} != 6'b0 || alu_y != 16'h0) begin
            seen_ctrl = {zx, nx, zy, ny, f, no};
            seen_y    = alu_y;
         end
         if (mem_req && mem_we) begin
            we_cycles++;
            we_addr = mem_addr;
            we_data = mem_wdata;
         end
         if (mem_req && !mem_we) begin
            if (rd_cycles > 0 && mem_addr != rd_addr) rd_addr_moved = 1'b1;
            rd_cycles++;
            rd_addr = mem_addr;
         end
         if (done) lat = c + 1;
      end
      if (lat == 0) check_eq("done_timeout", 32'd0, 32'd1);
      @(negedge clock);
   endtask

   int lat;
   int wr_before;

   initial begin
      // Reset state
      #2;
      check_eq("rst_ready", instr_ready, 1'b0);
      check_eq("rst_pc", pc, 15'd0);
      check_eq("rst_mem_req", mem_req, 1'b0);
      check_eq("rst_done", done, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1 check_eq("ready_after_rst", instr_ready, 1'b1);
      @(negedge clock);

      // @5
      run_instr(16'h0005, lat);
      check_eq("a_lat", lat, 2);
      check_eq("a_a_reg", a_reg, 16'd5);
      check_eq("a_pc", pc, 15'd1);
      check_eq("a_d_reg", d_reg, 16'd0);
      check_eq("a_no_alu_drive", {seen_ctrl, seen_y}, 22'd0);
      check_eq("done_pulse_width", done, 1'b0);

      // D=A with A=5
      run_instr(16'hEC10, lat);
      check_eq("dA_lat", lat, 3);
      check_eq("dA_ctrl", seen_ctrl, 6'b110000);
      check_eq("dA_alu_y", seen_y, 16'd5);
      check_eq("dA_d_reg", d_reg, 16'd5);
      check_eq("dA_pc", pc, 15'd2);

      // D=9, A=7, then M=D+1
      run_instr(16'h0009, lat);
      run_instr(16'hEC10, lat);
      run_instr(16'h0007, lat);
      check_eq("setup_d9", d_reg, 16'd9);
      wr_before = wr_count;
      run_instr(16'hE7C8, lat);
      check_eq("mw_lat", lat, 4);
      check_eq("mw_we_cycles", we_cycles, 1);
      check_eq("mw_addr", we_addr, 15'd7);
      check_eq("mw_wdata", we_data, 16'd10);
      check_eq("mw_a_unchanged", a_reg, 16'd7);
      check_eq("mw_writes", wr_count - wr_before, 1);
      check_eq("mw_pc", pc, 15'd6);

      // D=M with A=7, single-cycle fetch (ack_delay=0)
      rd_val = 16'h1234;
      run_instr(16'hFC10, lat);
      check_eq("dM_lat", lat, 4);
      check_eq("dM_rd_cycles", rd_cycles, 1);
      check_eq("dM_rd_addr", rd_addr, 15'd7);
      check_eq("dM_d_reg", d_reg, 16'h1234);
      check_eq("dM_pc", pc, 15'd7);

      // D;JEQ to 100, taken with D=0
      run_instr(16'h0000, lat);
      run_instr(16'hEC10, lat);
      run_instr(16'h0064, lat);
      run_instr(16'hE302, lat);
      check_eq("jeq_taken_lat", lat, 3);
      check_eq("jeq_taken_pc", pc, 15'd100);

      // Not taken with D=1
      run_instr(16'h0001, lat);
      run_instr(16'hEC10, lat);
      run_instr(16'h0064, lat);
      check_eq("jeq_pre_pc", pc, 15'd103);
      run_instr(16'hE302, lat);
      check_eq("jeq_not_taken_pc", pc, 15'd104);

      // Unconditional jump to 32767, then pc wraps to 0
      run_instr(16'h7FFF, lat);
      check_eq("a_max", a_reg, 16'h7FFF);
      run_instr(16'hE307, lat);
      check_eq("jmp_pc_max", pc, 15'h7FFF);
      run_instr(16'h0003, lat);
      check_eq("pc_wrap", pc, 15'd0);
      check_eq("a_after_wrap", a_reg, 16'd3);

`ifdef HACK_ALU_SEQ_MEM_WAIT_EN
      // D=M with ack held off for 3 cycles
      rd_val = 16'hBEEF;
      ack_delay = 3;
      run_instr(16'hFC10, lat);
      check_eq("wait_rd_cycles", rd_cycles, 4);
      check_eq("wait_addr_stable", rd_addr_moved, 1'b0);
      check_eq("wait_rd_addr", rd_addr, 15'd3);
      check_eq("wait_d_reg", d_reg, 16'hBEEF);
      check_eq("wait_lat", lat, 7);
      ack_delay = 0;
`endif

      // Reset asserted during WRITEM (M=D+1 with A=3)
      wr_before = wr_count;
      instr = 16'hE7C8;
      instr_valid = 1'b1;
      @(posedge clock);
      #1 instr_valid = 1'b0;
      for (int c = 0; c < 10 && !(mem_req && mem_we); c++) @(negedge clock);
      check_eq("rst_mid_in_writem", mem_req && mem_we, 1'b1);
      reset_n = 1'b0;
      #1;
      check_eq("rst_mid_we", mem_we, 1'b0);
      check_eq("rst_mid_req", mem_req, 1'b0);
      check_eq("rst_mid_pc", pc, 15'd0);
      check_eq("rst_mid_a", a_reg, 16'd0);
      check_eq("rst_mid_d", d_reg, 16'd0);
      check_eq("rst_mid_ready", instr_ready, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1 check_eq("rst_mid_ready_after", instr_ready, 1'b1);
      check_eq("rst_mid_no_write", wr_count - wr_before, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
